// File: rtl/feature_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : feature_stream_reader_pkg
// Purpose  : Shared types and constants for the feature stream reader:
//            FSM state encoding, default path widths and output buffer depth.
// Ports    : none (package)
// Options  : FEATURE_STREAM_READER_DESCEND_EN (used by the top, not here)
// Revision : 1.0 - initial release
// ============================================================================
package feature_stream_reader_pkg;

    localparam int c_addr_w    = 12;
    localparam int c_data_w    = 16;

    // Output buffer depth. It also bounds the number of outstanding reads.
    // Must be a power of two so the buffer pointers wrap naturally.
    localparam int c_buf_depth = 2;
    localparam int c_cnt_w     = $clog2(c_buf_depth + 1);
    localparam int c_ptr_w     = $clog2(c_buf_depth);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } fsr_state_t;

endpackage
`default_nettype wire

// File: rtl/fsr_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : fsr_skid_buf
// Purpose  : Small FIFO holding {data, index, last} words returned by the RAM
//            while the downstream consumer stalls.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            in_valid/in_ready - write side handshake
//            in_data/in_index/in_last - word written
//            out_valid/out_ready - read side handshake
//            out_data/out_index/out_last - head word
//            count             - current occupancy, used for read credit
// Revision : 1.0 - initial release
// ============================================================================
module fsr_skid_buf
    import feature_stream_reader_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [ADDR_W-1:0]  in_index,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [ADDR_W-1:0]  out_index,
    output logic               out_last,
    output logic [c_cnt_w-1:0] count
);

    logic [DATA_W-1:0]      r_data  [c_buf_depth];
    logic [ADDR_W-1:0]      r_index [c_buf_depth];
    logic [c_buf_depth-1:0] r_last;
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_cnt_w-1:0]     r_count;
    logic                   w_push;
    logic                   w_pop;

    assign in_ready  = (r_count != c_cnt_w'(c_buf_depth));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign out_data  = r_data[r_rd_ptr];
    assign out_index = r_index[r_rd_ptr];
    assign out_last  = r_last[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_buf_depth; i++) begin
                r_data[i]  <= '0;
                r_index[i] <= '0;
            end
            r_last   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr]  <= in_data;
                r_index[r_wr_ptr] <= in_index;
                r_last[r_wr_ptr]  <= in_last;
                r_wr_ptr          <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/feature_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : feature_stream_reader
// Purpose  : Walks a block of addresses in a synchronous single-port RAM and
//            presents the returned feature words as a valid/ready stream,
//            tagged with their address and a last flag, then pulses done.
// Ports    : clk, rst              - clock, asynchronous active-high reset
//            start, max_count      - begin a block covering 0..max_count
//            descend               - walk max_count..0 (optional, see below)
//            busy, done            - block in progress / 1-cycle completion
//            mem_en, mem_addr      - RAM read request
//            mem_rdata             - RAM data, one cycle after mem_en
//            out_valid, out_ready  - stream handshake
//            out_data, out_index, out_last - stream payload
// Options  : FEATURE_STREAM_READER_DESCEND_EN adds the descend input.
// Revision : 1.0 - initial release
// ============================================================================
module feature_stream_reader
    import feature_stream_reader_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] max_count,
`ifdef FEATURE_STREAM_READER_DESCEND_EN
    input  logic              descend,
`endif
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last
);

    localparam int c_out_w = c_cnt_w + 1;

    fsr_state_t         r_state;
    fsr_state_t         w_state_nxt;

    logic [ADDR_W-1:0]  r_lim;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_descend;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_inflight_idx;
    logic               r_inflight_last;

    logic               w_descend_in;
    logic               w_start_acc;
    logic               w_issue;
    logic               w_issue_last;
    logic               w_credit;
    logic [c_out_w-1:0] w_outstanding;
    logic               w_last_accept;

    logic               w_buf_in_valid;
    logic               w_buf_in_ready;
    logic               w_buf_out_valid;
    logic [DATA_W-1:0]  w_buf_data;
    logic [ADDR_W-1:0]  w_buf_index;
    logic               w_buf_last;
    logic [c_cnt_w-1:0] w_buf_count;

`ifdef FEATURE_STREAM_READER_DESCEND_EN
    assign w_descend_in = descend;
`else
    assign w_descend_in = 1'b0;
`endif

    // A read may only be issued if its data is guaranteed a place to land:
    // every word already buffered or still returning from the RAM holds a slot.
    assign w_outstanding = {1'b0, w_buf_count} + {{c_cnt_w{1'b0}}, r_inflight};
    assign w_credit      = (w_outstanding < c_out_w'(c_buf_depth)) & w_buf_in_ready;
    assign w_issue_last  = r_descend ? (r_rd_addr == '0) : (r_rd_addr == r_lim);
    assign w_last_accept = out_valid & out_ready & out_last;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_issue     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = READ;
                end
            end
            READ: begin
                busy    = 1'b1;
                w_issue = w_credit;
                if (w_credit && w_issue_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // The last-flagged word is the final one issued, so its
                // acceptance also means the buffer and RAM pipe are empty.
                if (w_last_accept) begin
                    w_state_nxt = FINISH;
                end
            end
            FINISH: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign mem_en   = w_issue;
    assign mem_addr = w_issue ? r_rd_addr : '0;

    // ------------------------------------------------------------------------
    // Address walk and in-flight tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lim           <= '0;
            r_rd_addr       <= '0;
            r_descend       <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_idx  <= '0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_idx  <= r_rd_addr;
                r_inflight_last <= w_issue_last;
            end
            if (w_start_acc) begin
                r_lim     <= max_count;
                r_descend <= w_descend_in;
                r_rd_addr <= w_descend_in ? max_count : '0;
            end else if (w_issue && !w_issue_last) begin
                // The step past the final address is never taken, so a block
                // ending at the top (or bottom) of the range does not wrap.
                r_rd_addr <= r_descend ? (r_rd_addr - ADDR_W'(1))
                                       : (r_rd_addr + ADDR_W'(1));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output path: buffered words take priority; otherwise the word arriving
    // from the RAM is presented directly. A returning word goes into the
    // buffer unless it is consumed directly this cycle, which keeps the
    // presented word stable across stalls and keeps out_ready off any path
    // into out_valid or out_data.
    // ------------------------------------------------------------------------
    assign w_buf_in_valid = r_inflight & (w_buf_out_valid | ~out_ready);
    assign out_valid      = w_buf_out_valid | r_inflight;

    always_comb begin
        out_data  = '0;
        out_index = '0;
        out_last  = 1'b0;
        if (w_buf_out_valid) begin
            out_data  = w_buf_data;
            out_index = w_buf_index;
            out_last  = w_buf_last;
        end else if (r_inflight) begin
            out_data  = mem_rdata;
            out_index = r_inflight_idx;
            out_last  = r_inflight_last;
        end
    end

    fsr_skid_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_buf_in_valid),
        .in_ready  (w_buf_in_ready),
        .in_data   (mem_rdata),
        .in_index  (r_inflight_idx),
        .in_last   (r_inflight_last),
        .out_valid (w_buf_out_valid),
        .out_ready (out_ready),
        .out_data  (w_buf_data),
        .out_index (w_buf_index),
        .out_last  (w_buf_last),
        .count     (w_buf_count)
    );

endmodule
`default_nettype wire

// File: doc/feature_stream_reader.md
Name: feature_stream_reader

Overview:
- Reads a contiguous block of feature words from a synchronous single-port RAM and presents them as a valid/ready stream to the decision-tree evaluator.
- Generates the read addresses that the upstream writer filled. It walks addresses 0..max_count and reports completion with a done pulse.
- Absorbs downstream backpressure against the fixed 1-cycle RAM read latency using an internal 2-entry buffer.

Parameters:
- ADDR_W, 12, width of the address/count path and of max_count.
- DATA_W, 16, feature word width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high; clears all state immediately.
- start  in  1  1-cycle request to begin a block read; sampled only in IDLE.
- max_count  in  ADDR_W  last address of the block (inclusive); captured on accepted start.
- busy  out  1  high from the cycle after start is accepted until done is asserted.
- done  out  1  1-cycle pulse after the last word is accepted downstream.
- mem_en  out  1  RAM read enable.
- mem_addr  out  ADDR_W  RAM read address.
- mem_rdata  in  DATA_W  RAM data, valid exactly one cycle after mem_en.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  feature word.
- out_index  out  ADDR_W  address the word was read from.
- out_last  out  1  high with the word whose index equals the captured max_count.

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - busy, done, mem_en, out_valid and out_last are 0.
  - mem_addr, out_data and out_index are 0.
  - The FSM is in IDLE and the buffer is empty.
- FSM states: IDLE, READ, DRAIN, FINISH.
  - IDLE -> READ on start. Captures max_count into lim_q and clears rd_addr to 0.
  - READ: issues mem_en=1, mem_addr=rd_addr when credit is available. Credit means buffer occupancy + in-flight reads < 2. The last address (rd_addr == lim_q) is issued -> DRAIN.
  - DRAIN: no further reads. Stays until the buffer is empty and nothing is in flight, and the out_last word is accepted -> FINISH.
  - FINISH: done=1 for exactly one cycle -> IDLE. busy falls in the same cycle done rises.
- Reads:
  - rd_addr increments by 1 per issued read and never wraps inside a block.
  - max_count = 2^ADDR_W-1 is legal; the final increment is not used.
  - max_count = 0 produces exactly one word with out_last=1.
- Stream rules:
  - Once out_valid=1, out_valid, out_data, out_index and out_last hold stable until out_valid&out_ready.
  - There is no combinational path from out_ready to out_valid or out_data.
  - With out_ready held 1, the stream sustains 1 word/cycle after a 2-cycle start-to-first-valid latency: start at cycle N, first mem_en at N+1, out_valid at N+2.
  - When out_ready is low, in-flight data is captured in the buffer, never dropped. Reads stop at 2 outstanding.
- Ignored inputs:
  - start while busy is ignored, and max_count is not re-captured.
  - start in the same cycle as FINISH is ignored; it is accepted only in IDLE.
- Reset mid-block: all outputs return to reset values asynchronously. In-flight RAM data returning after reset is discarded. No done pulse is produced.

Optional Feature:
- Macro: FEATURE_STREAM_READER_DESCEND_EN.
- Defined:
  - Adds input port descend (1 bit), captured on accepted start.
  - With descend=1, rd_addr starts at max_count and decrements to 0. out_last is asserted with index 0.
  - With descend=0, behaviour is as above.
- Undefined: the port is absent and the order is always ascending.

Decomposition:
- Package feature_stream_reader_pkg holds:
  - FSM state typedef (IDLE, READ, DRAIN, FINISH).
  - Default ADDR_W and DATA_W constants.
  - Buffer depth constant = 2.
- One sub-module, fsr_skid_buf: 2-entry {data, index, last} FIFO with valid/ready on both sides and a count output used for credit.

Test Plan:
- max_count=3, out_ready=1, RAM[i]=0x100+i, start at cycle 0:
  - out_valid cycles 2-5 with data 0x100..0x103 and index 0..3.
  - out_last at cycle 5, done at cycle 6, busy low at cycle 6.
- max_count=0:
  - One word index 0 with out_last=1, then a single done pulse; mem_en asserted exactly once.
- max_count=7, out_ready toggling 1,0,0,1,...:
  - All 8 words arrive in order, stable while stalled, with no duplicates.
  - Never more than 2 reads outstanding.
- start pulsed again mid-block with max_count=2 during a max_count=5 block:
  - Exactly 6 words and out_last on index 5; the second start is ignored.
- rst asserted while the word at index 3 is in flight:
  - Outputs cleared in the same cycle and no done pulse.
  - A following start with max_count=1 yields indices 0,1 only.
- DESCEND_EN defined, descend=1, max_count=4:
  - Indices 4,3,2,1,0 in order, out_last on index 0, then done.
